// File: rtl/rv32_pkg.sv
// RV32I opcode constants, immediate formats and instruction field positions.
package rv32_pkg;

    localparam int unsigned INSTR_WIDTH  = 32;
    localparam int unsigned OPC_WIDTH    = 7;

    localparam logic [6:0] OPCODE_OP     = 7'b0110011;
    localparam logic [6:0] OPCODE_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPCODE_LOAD   = 7'b0000011;
    localparam logic [6:0] OPCODE_STORE  = 7'b0100011;
    localparam logic [6:0] OPCODE_BRANCH = 7'b1100011;
    localparam logic [6:0] OPCODE_JAL    = 7'b1101111;
    localparam logic [6:0] OPCODE_JALR   = 7'b1100111;
    localparam logic [6:0] OPCODE_LUI    = 7'b0110111;
    localparam logic [6:0] OPCODE_AUIPC  = 7'b0010111;

    localparam int unsigned RD_LSB     = 7;
    localparam int unsigned FUNCT3_LSB = 12;
    localparam int unsigned RS1_LSB    = 15;
    localparam int unsigned RS2_LSB    = 20;
    localparam int unsigned FUNCT7_LSB = 25;

    localparam logic [2:0] FUNCT3_SR   = 3'b101;

    typedef enum logic [2:0] {
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_NONE
    } imm_fmt_e;

    // True for every opcode this decoder supports.
    function automatic logic opcode_legal(input logic [6:0] opc);
        case (opc)
            OPCODE_OP, OPCODE_OP_IMM, OPCODE_LOAD, OPCODE_STORE, OPCODE_BRANCH,
            OPCODE_JAL, OPCODE_JALR, OPCODE_LUI, OPCODE_AUIPC: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/imm_gen.sv
// Immediate generator: classifies the instruction format and builds the sign-extended immediate.
module imm_gen
    import rv32_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32
) (
    input  logic [DATA_WIDTH-1:0] instr,
    output imm_fmt_e              fmt_c,
    output logic [DATA_WIDTH-1:0] imm_c
);

    logic [31:0] imm32;

    // Opcode to immediate format; OP and unsupported opcodes carry no immediate.
    always_comb begin
        fmt_c = FMT_NONE;
        case (instr[6:0])
            OPCODE_OP_IMM, OPCODE_LOAD, OPCODE_JALR: fmt_c = FMT_I;
            OPCODE_STORE:                            fmt_c = FMT_S;
            OPCODE_BRANCH:                           fmt_c = FMT_B;
            OPCODE_LUI, OPCODE_AUIPC:                fmt_c = FMT_U;
            OPCODE_JAL:                              fmt_c = FMT_J;
            default:                                 fmt_c = FMT_NONE;
        endcase
    end

    // Bit scatter per format, all sign-extended from instr[31].
    always_comb begin
        imm32 = 32'd0;
        case (fmt_c)
            FMT_I: imm32 = {{20{instr[31]}}, instr[31:20]};
            FMT_S: imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            FMT_B: imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            FMT_U: imm32 = {instr[31:12], 12'd0};
            FMT_J: imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm32 = 32'd0;
        endcase
    end

    assign imm_c = DATA_WIDTH'($signed(imm32));

endmodule

// File: rtl/decode_stage.sv
// RV32I decode stage: register read, immediate generation and a single valid/ready output register.
module decode_stage
    import rv32_pkg::*;
#(
    parameter int unsigned DATA_WIDTH     = 32,
    parameter int unsigned OPCODE_WIDTH   = 7,
    parameter int unsigned REG_ADDR_WIDTH = 5
) (
    input  logic                      CLK,
    input  logic                      RST,
    input  logic                      IF_VALID,
    output logic                      IF_READY,
    input  logic [DATA_WIDTH-1:0]     IF_INSTR,
    input  logic [DATA_WIDTH-1:0]     IF_PC,
    input  logic                      FLUSH,
    output logic [REG_ADDR_WIDTH-1:0] RF_RS1_ADDR,
    output logic [REG_ADDR_WIDTH-1:0] RF_RS2_ADDR,
    input  logic [DATA_WIDTH-1:0]     RF_RS1_DATA,
    input  logic [DATA_WIDTH-1:0]     RF_RS2_DATA,
    output logic                      EX_VALID,
    input  logic                      EX_READY,
    output logic [DATA_WIDTH-1:0]     PC_OUT,
    output logic [DATA_WIDTH-1:0]     RS1_OUT,
    output logic [DATA_WIDTH-1:0]     RS2_OUT,
    output logic [DATA_WIDTH-1:0]     IMM_OUT,
    output logic [OPCODE_WIDTH-1:0]   OPCODE,
    output logic [2:0]                FUNCT3,
    output logic [6:0]                FUNCT7,
    output logic [REG_ADDR_WIDTH-1:0] RD_ADDR,
    output logic                      MUX1_CTRL,
    output logic                      ILLEGAL
);

    logic [6:0]                opcode_c;
    logic [2:0]                funct3_c;
    logic                      legal_c;
    logic                      if_ready_c;
    logic                      xfer_c;
    logic [DATA_WIDTH-1:0]     rs1_val_c;
    logic [DATA_WIDTH-1:0]     rs2_val_c;
    logic [DATA_WIDTH-1:0]     imm_c;
    logic [6:0]                funct7_c;
    logic [REG_ADDR_WIDTH-1:0] rd_c;
    logic                      mux1_c;
    imm_fmt_e                  fmt_c;

    imm_gen #(.DATA_WIDTH(DATA_WIDTH)) u_imm_gen (
        .instr (IF_INSTR),
        .fmt_c (fmt_c),
        .imm_c (imm_c)
    );

    assign opcode_c    = IF_INSTR[6:0];
    assign funct3_c    = IF_INSTR[FUNCT3_LSB +: 3];
    assign legal_c     = opcode_legal(opcode_c);
    assign RF_RS1_ADDR = IF_INSTR[RS1_LSB +: REG_ADDR_WIDTH];
    assign RF_RS2_ADDR = IF_INSTR[RS2_LSB +: REG_ADDR_WIDTH];

    // Handshake: a held entry that is not being consumed blocks fetch; reset blocks it too.
    assign if_ready_c = !RST && (!EX_VALID || EX_READY);
    assign xfer_c     = IF_VALID && if_ready_c && !FLUSH;
    assign IF_READY   = if_ready_c;

    // Operand and control-field decode for the incoming instruction.
    always_comb begin
        rs1_val_c = (RF_RS1_ADDR == '0) ? '0 : RF_RS1_DATA;
        rs2_val_c = (RF_RS2_ADDR == '0) ? '0 : RF_RS2_DATA;

        // Only register-register ops and right shifts use funct7; zeroing it elsewhere
        // keeps immediate bits from aliasing as SUB/SRA.
        funct7_c = 7'd0;
        if ((opcode_c == OPCODE_OP) ||
            ((opcode_c == OPCODE_OP_IMM) && (funct3_c == FUNCT3_SR))) begin
            funct7_c = IF_INSTR[FUNCT7_LSB +: 7];
        end

        rd_c = IF_INSTR[RD_LSB +: REG_ADDR_WIDTH];
        if (!legal_c || (opcode_c == OPCODE_BRANCH) || (opcode_c == OPCODE_STORE)) begin
            rd_c = '0;
        end

        mux1_c = (opcode_c == OPCODE_BRANCH) || (opcode_c == OPCODE_JAL) ||
                 (opcode_c == OPCODE_JALR)   || (opcode_c == OPCODE_AUIPC);
    end

    // Pipeline register: reset > flush > capture > drain; otherwise hold.
    always_ff @(posedge CLK) begin
        if (RST) begin
            EX_VALID  <= 1'b0;
            PC_OUT    <= '0;
            RS1_OUT   <= '0;
            RS2_OUT   <= '0;
            IMM_OUT   <= '0;
            OPCODE    <= '0;
            FUNCT3    <= '0;
            FUNCT7    <= '0;
            RD_ADDR   <= '0;
            MUX1_CTRL <= 1'b0;
            ILLEGAL   <= 1'b0;
        end else if (FLUSH) begin
            EX_VALID  <= 1'b0;
        end else if (xfer_c) begin
            EX_VALID  <= 1'b1;
            PC_OUT    <= IF_PC;
            RS1_OUT   <= rs1_val_c;
            RS2_OUT   <= rs2_val_c;
            IMM_OUT   <= (legal_c && (fmt_c != FMT_NONE)) ? imm_c : '0;
            OPCODE    <= IF_INSTR[OPCODE_WIDTH-1:0];
            FUNCT3    <= funct3_c;
            FUNCT7    <= funct7_c;
            RD_ADDR   <= rd_c;
            MUX1_CTRL <= mux1_c;
            ILLEGAL   <= !legal_c;
        end else if (EX_READY) begin
            EX_VALID  <= 1'b0;
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed test-plan cases plus randomized traffic against a model.
module tb_decode_stage;

    logic        CLK;
    logic        RST;
    logic        IF_VALID;
    logic        IF_READY;
    logic [31:0] IF_INSTR;
    logic [31:0] IF_PC;
    logic        FLUSH;
    logic [4:0]  RF_RS1_ADDR;
    logic [4:0]  RF_RS2_ADDR;
    logic [31:0] RF_RS1_DATA;
    logic [31:0] RF_RS2_DATA;
    logic        EX_VALID;
    logic        EX_READY;
    logic [31:0] PC_OUT;
    logic [31:0] RS1_OUT;
    logic [31:0] RS2_OUT;
    logic [31:0] IMM_OUT;
    logic [6:0]  OPCODE;
    logic [2:0]  FUNCT3;
    logic [6:0]  FUNCT7;
    logic [4:0]  RD_ADDR;
    logic        MUX1_CTRL;
    logic        ILLEGAL;

    decode_stage dut (
        .CLK(CLK), .RST(RST), .IF_VALID(IF_VALID), .IF_READY(IF_READY),
        .IF_INSTR(IF_INSTR), .IF_PC(IF_PC), .FLUSH(FLUSH),
        .RF_RS1_ADDR(RF_RS1_ADDR), .RF_RS2_ADDR(RF_RS2_ADDR),
        .RF_RS1_DATA(RF_RS1_DATA), .RF_RS2_DATA(RF_RS2_DATA),
        .EX_VALID(EX_VALID), .EX_READY(EX_READY),
        .PC_OUT(PC_OUT), .RS1_OUT(RS1_OUT), .RS2_OUT(RS2_OUT), .IMM_OUT(IMM_OUT),
        .OPCODE(OPCODE), .FUNCT3(FUNCT3), .FUNCT7(FUNCT7), .RD_ADDR(RD_ADDR),
        .MUX1_CTRL(MUX1_CTRL), .ILLEGAL(ILLEGAL)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1;
        logic [31:0] rs2;
        logic [31:0] imm;
        logic [6:0]  op;
        logic [2:0]  f3;
        logic [6:0]  f7;
        logic [4:0]  rd;
        logic        mux;
        logic        ill;
    } ent_t;

    int   errors = 0;
    int   checks = 0;
    logic m_valid;
    logic m_zero;
    ent_t m_ent;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Sign-extend the low n bits of v.
    function automatic logic [31:0] sext(input longint v, input int n);
        longint r;
        r = v;
        if (((v >> (n - 1)) & 1) != 0) r = v - (longint'(1) << n);
        return 32'(r);
    endfunction

    // Architectural decode of one instruction, from the ISA field definitions.
    function automatic ent_t decode(input logic [31:0] ins, input logic [31:0] pc,
                                    input logic [31:0] d1, input logic [31:0] d2);
        ent_t   e;
        longint w;
        int     opc, f3, rs1, rs2, rd;
        w   = longint'(ins);
        opc = int'(w & 127);
        f3  = int'((w >> 12) & 7);
        rd  = int'((w >> 7) & 31);
        rs1 = int'((w >> 15) & 31);
        rs2 = int'((w >> 20) & 31);
        e     = '0;
        e.pc  = pc;
        e.rs1 = (rs1 == 0) ? 32'd0 : d1;
        e.rs2 = (rs2 == 0) ? 32'd0 : d2;
        e.op  = 7'(opc);
        e.f3  = 3'(f3);
        e.rd  = 5'(rd);
        case (opc)
            'h33: e.f7 = 7'(w >> 25);
            'h13: begin
                e.imm = sext(w >> 20, 12);
                if (f3 == 5) e.f7 = 7'(w >> 25);
            end
            'h03: e.imm = sext(w >> 20, 12);
            'h67: begin e.imm = sext(w >> 20, 12); e.mux = 1'b1; end
            'h23: begin e.imm = sext(((w >> 25) << 5) | ((w >> 7) & 31), 12); e.rd = 5'd0; end
            'h63: begin
                e.imm = sext((((w >> 31) & 1) << 12) | (((w >> 7) & 1) << 11) |
                             (((w >> 25) & 63) << 5) | (((w >> 8) & 15) << 1), 13);
                e.rd  = 5'd0;
                e.mux = 1'b1;
            end
            'h37: e.imm = 32'(w & 'hFFFFF000);
            'h17: begin e.imm = 32'(w & 'hFFFFF000); e.mux = 1'b1; end
            'h6F: begin
                e.imm = sext((((w >> 31) & 1) << 20) | (((w >> 12) & 255) << 12) |
                             (((w >> 20) & 1) << 11) | (((w >> 21) & 1023) << 1), 21);
                e.mux = 1'b1;
            end
            default: begin e.ill = 1'b1; e.rd = 5'd0; end
        endcase
        return e;
    endfunction

    // One cycle: drive inputs, check DUT against model, advance model.
    task automatic step(input logic rst, input logic iv, input logic [31:0] ins,
                        input logic [31:0] pc, input logic fl, input logic [31:0] d1,
                        input logic [31:0] d2, input logic er);
        logic rdy;
        @(negedge CLK);
        RST = rst; IF_VALID = iv; IF_INSTR = ins; IF_PC = pc; FLUSH = fl;
        RF_RS1_DATA = d1; RF_RS2_DATA = d2; EX_READY = er;
        #1;
        rdy = !rst && (!m_valid || er);
        chk("if_ready", 32'(IF_READY), 32'(rdy));
        chk("rf_rs1_addr", 32'(RF_RS1_ADDR), (ins >> 15) & 32'd31);
        chk("rf_rs2_addr", 32'(RF_RS2_ADDR), (ins >> 20) & 32'd31);
        chk("ex_valid", 32'(EX_VALID), 32'(m_valid));
        if (m_valid || m_zero) begin
            chk("pc_out", PC_OUT, m_ent.pc);
            chk("rs1_out", RS1_OUT, m_ent.rs1);
            chk("rs2_out", RS2_OUT, m_ent.rs2);
            chk("imm_out", IMM_OUT, m_ent.imm);
            chk("opcode", 32'(OPCODE), 32'(m_ent.op));
            chk("funct3", 32'(FUNCT3), 32'(m_ent.f3));
            chk("funct7", 32'(FUNCT7), 32'(m_ent.f7));
            chk("rd_addr", 32'(RD_ADDR), 32'(m_ent.rd));
            chk("mux1_ctrl", 32'(MUX1_CTRL), 32'(m_ent.mux));
            chk("illegal", 32'(ILLEGAL), 32'(m_ent.ill));
        end
        if (rst) begin
            m_valid = 1'b0; m_zero = 1'b1; m_ent = '0;
        end else if (fl) begin
            m_valid = 1'b0;
        end else if (iv && rdy) begin
            m_valid = 1'b1; m_zero = 1'b0; m_ent = decode(ins, pc, d1, d2);
        end else if (er) begin
            m_valid = 1'b0;
        end
    endtask

    task automatic idle(input logic er);
        step(1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0, 32'h0, er);
    endtask

    function automatic logic [31:0] rand_instr();
        logic [6:0]  opcs [10];
        logic [31:0] ins;
        opcs = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h63, 7'h6F, 7'h67, 7'h37, 7'h17, 7'h00};
        ins = $urandom;
        opcs[9] = 7'($urandom);
        ins[6:0] = opcs[$urandom_range(0, 9)];
        if ($urandom_range(0, 3) == 0) ins[19:15] = 5'd0;
        if ($urandom_range(0, 3) == 0) ins[24:20] = 5'd0;
        if ($urandom_range(0, 2) == 0) ins[14:12] = 3'b101;
        return ins;
    endfunction

    initial begin
        CLK = 1'b0; RST = 1'b1; IF_VALID = 1'b0; IF_INSTR = '0; IF_PC = '0; FLUSH = 1'b0;
        RF_RS1_DATA = '0; RF_RS2_DATA = '0; EX_READY = 1'b0;
        repeat (2) @(posedge CLK);
        m_valid = 1'b0; m_zero = 1'b1; m_ent = '0;

        // Reset state
        idle(1'b1);
        chk("lit_reset_valid", 32'(EX_VALID), 32'd0);
        chk("lit_reset_imm", IMM_OUT, 32'd0);

        // ADDI x1,x2,-1
        step(1'b0, 1'b1, 32'hFFF10093, 32'h40, 1'b0, 32'h10, 32'h77, 1'b1);
        idle(1'b0);
        chk("lit_addi_valid", 32'(EX_VALID), 32'd1);
        chk("lit_addi_opcode", 32'(OPCODE), 32'h13);
        chk("lit_addi_funct7", 32'(FUNCT7), 32'h0);
        chk("lit_addi_imm", IMM_OUT, 32'hFFFFFFFF);
        chk("lit_addi_rs1", RS1_OUT, 32'h10);
        chk("lit_addi_rd", 32'(RD_ADDR), 32'd1);
        chk("lit_addi_mux1", 32'(MUX1_CTRL), 32'd0);

        // SRAI x3,x4,5
        step(1'b0, 1'b1, 32'h40525193, 32'h44, 1'b0, 32'h5, 32'h6, 1'b1);
        idle(1'b0);
        chk("lit_srai_funct3", 32'(FUNCT3), 32'd5);
        chk("lit_srai_funct7", 32'(FUNCT7), 32'h20);
        chk("lit_srai_imm", IMM_OUT, 32'h405);
        chk("lit_srai_rd", 32'(RD_ADDR), 32'd3);

        // BEQ x0,x0,-4 at 0x100
        step(1'b0, 1'b1, 32'hFE000EE3, 32'h100, 1'b0, 32'hDEAD, 32'hDEAD, 1'b1);
        idle(1'b0);
        chk("lit_beq_imm", IMM_OUT, 32'hFFFFFFFC);
        chk("lit_beq_pc", PC_OUT, 32'h100);
        chk("lit_beq_mux1", 32'(MUX1_CTRL), 32'd1);
        chk("lit_beq_rd", 32'(RD_ADDR), 32'd0);
        chk("lit_beq_rs1", RS1_OUT, 32'd0);
        chk("lit_beq_rs2", RS2_OUT, 32'd0);

        // Stall with fetch pending, then release
        step(1'b0, 1'b1, 32'h002081B3, 32'h200, 1'b0, 32'h1, 32'h2, 1'b1);
        for (int i = 0; i < 3; i++) begin
            step(1'b0, 1'b1, 32'h00310233, 32'h204, 1'b0, 32'h3, 32'h4, 1'b0);
            chk("lit_stall_if_ready", 32'(IF_READY), 32'd0);
            chk("lit_stall_pc", PC_OUT, 32'h200);
        end
        step(1'b0, 1'b1, 32'h00310233, 32'h204, 1'b0, 32'h3, 32'h4, 1'b1);
        idle(1'b1);
        chk("lit_release_pc", PC_OUT, 32'h204);
        chk("lit_release_valid", 32'(EX_VALID), 32'd1);
        idle(1'b1);
        chk("lit_release_drained", 32'(EX_VALID), 32'd0);

        // Flush with a held entry and a pending fetch
        step(1'b0, 1'b1, 32'h00000013, 32'h300, 1'b0, 32'h0, 32'h0, 1'b1);
        step(1'b0, 1'b1, 32'h00100093, 32'h304, 1'b1, 32'h0, 32'h0, 1'b0);
        idle(1'b0);
        chk("lit_flush_valid", 32'(EX_VALID), 32'd0);
        step(1'b0, 1'b1, 32'h00000013, 32'h308, 1'b0, 32'h0, 32'h0, 1'b1);
        step(1'b1, 1'b1, 32'h00100093, 32'h30C, 1'b1, 32'h0, 32'h0, 1'b0);
        idle(1'b0);
        chk("lit_flushrst_valid", 32'(EX_VALID), 32'd0);
        chk("lit_flushrst_pc", PC_OUT, 32'd0);

        // Illegal opcode, then reset in the middle of a stall
        step(1'b0, 1'b1, 32'hFFFFFFFF, 32'h400, 1'b0, 32'h9, 32'h9, 1'b1);
        idle(1'b0);
        chk("lit_illegal_valid", 32'(EX_VALID), 32'd1);
        chk("lit_illegal_flag", 32'(ILLEGAL), 32'd1);
        chk("lit_illegal_imm", IMM_OUT, 32'd0);
        chk("lit_illegal_opcode", 32'(OPCODE), 32'h7F);
        step(1'b1, 1'b1, 32'h00100093, 32'h404, 1'b0, 32'h0, 32'h0, 1'b0);
        idle(1'b0);
        chk("lit_rststall_valid", 32'(EX_VALID), 32'd0);
        chk("lit_rststall_pc", PC_OUT, 32'd0);
        chk("lit_rststall_illegal", 32'(ILLEGAL), 32'd0);

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            step(1'($urandom_range(0, 63) == 0), 1'($urandom_range(0, 3) != 0), rand_instr(),
                 $urandom, 1'($urandom_range(0, 9) == 0), $urandom, $urandom,
                 1'($urandom_range(0, 2) != 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_stage.md
Name: decode_stage

Overview:
RV32I instruction decode stage. It sits between the fetch unit and the ALU top level, producing every operand and control field the ALU top consumes: PC, RS1, RS2, IMM, OPCODE, FUNCT3, FUNCT7 and MUX1_CTRL. It reads the register file, generates immediates, and holds its results in a single valid/ready pipeline register. Stall, flush and reset are supported.

Parameters:
DATA_WIDTH, 32, width of instruction, PC, operands and immediate
OPCODE_WIDTH, 7, opcode field width
REG_ADDR_WIDTH, 5, register index width

Ports:
CLK  in  1  clock, rising edge
RST  in  1  synchronous, active-high reset
IF_VALID  in  1  fetch presents an instruction
IF_READY  out  1  stage accepts an instruction this cycle
IF_INSTR  in  DATA_WIDTH  instruction word
IF_PC  in  DATA_WIDTH  instruction address
FLUSH  in  1  discard the held entry and the incoming instruction
RF_RS1_ADDR  out  REG_ADDR_WIDTH  register-file read address 1, = IF_INSTR[19:15]
RF_RS2_ADDR  out  REG_ADDR_WIDTH  register-file read address 2, = IF_INSTR[24:20]
RF_RS1_DATA  in  DATA_WIDTH  combinational read data 1
RF_RS2_DATA  in  DATA_WIDTH  combinational read data 2
EX_VALID  out  1  decoded entry valid
EX_READY  in  1  execute stage consumes the entry
PC_OUT, RS1_OUT, RS2_OUT, IMM_OUT  out  DATA_WIDTH  registered operands
OPCODE  out  OPCODE_WIDTH  registered opcode
FUNCT3  out  3  registered funct3
FUNCT7  out  7  registered, sanitised funct7
RD_ADDR  out  REG_ADDR_WIDTH  destination register
MUX1_CTRL  out  1  PC-relative instruction flag
ILLEGAL  out  1  unsupported opcode flag

Behaviour:
- Clocking: one clock, CLK. RST is synchronous and active-high.
- Reset: EX_VALID=0, ILLEGAL=0, and all data outputs are 0. Reset overrides FLUSH and any transfer, including in the middle of a stall.
- Ready: IF_READY = !EX_VALID | EX_READY (combinational), forced 0 while RST=1.
- Accept: a transfer occurs when IF_VALID & IF_READY & !FLUSH. The decoded fields are captured at that edge and EX_VALID=1 the next cycle. Latency is 1 cycle.
- Stall: while EX_VALID & !EX_READY, every output register holds its value bit-for-bit.
- Drain: if EX_READY=1 and there is no new transfer, EX_VALID goes to 0 the next cycle. Data registers may hold stale values.
- Flush: FLUSH=1 sets EX_VALID=0 at the next edge and blocks capture in the same cycle. FLUSH takes priority over a simultaneous transfer.
- Register x0: RS1_OUT/RS2_OUT capture 0 when the source address is 0, regardless of RF data.
- Immediate generation (sign-extended from instr[31]):
  - I-type: OP_IMM 0010011, LOAD 0000011, JALR 1100111
  - S-type: STORE 0100011
  - B-type: BRANCH 1100011, bit 0 = 0
  - U-type: LUI 0110111, AUIPC 0010111, low 12 bits = 0
  - J-type: JAL 1101111, bit 0 = 0
  - OP 0110011: IMM=0
- FUNCT7 sanitisation:
  - OP: FUNCT7 = instr[31:25].
  - OP_IMM with funct3=101 (shift right): FUNCT7 = instr[31:25].
  - All other opcodes: FUNCT7 = 0. This prevents, e.g., a negative ADDI immediate from being executed as SUB.
- MUX1_CTRL = 1 for BRANCH, JAL, JALR, AUIPC; otherwise 0.
- RD_ADDR = instr[11:7]. It is 0 for BRANCH and STORE.
- Illegal opcode: the entry is still issued with EX_VALID=1 and ILLEGAL=1. OPCODE is passed through; IMM, FUNCT7 and RD_ADDR are 0.

Decomposition:
- Shared package rv32_pkg: opcode localparams (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC), immediate-format enum (I/S/B/U/J/NONE), field bit positions.
- Combinational sub-module imm_gen: instruction word -> format and IMM.
- The pipeline register and handshake live in decode_stage.

Test Plan:
1. ADDI x1,x2,-1 (0xFFF10093), RF_RS1_DATA=0x10 -> next cycle: EX_VALID=1, OPCODE=0x13, FUNCT3=0, FUNCT7=0, IMM_OUT=0xFFFFFFFF, RS1_OUT=0x10, RD_ADDR=1, MUX1_CTRL=0.
2. SRAI x3,x4,5 (0x40525193) -> FUNCT3=5, FUNCT7=0x20, IMM_OUT=0x405 (shift amount in IMM_OUT[4:0]=5), RD_ADDR=3.
3. BEQ x0,x0,-4 (0xFE000EE3) at IF_PC=0x100 -> IMM_OUT=0xFFFFFFFC, PC_OUT=0x100, MUX1_CTRL=1, RD_ADDR=0, RS1_OUT=RS2_OUT=0 even with RF data=0xDEAD.
4. EX_READY=0 for 3 cycles with IF_VALID=1 -> IF_READY=0 and outputs frozen. On EX_READY=1, exactly one new instruction is accepted; no entry is lost or duplicated.
5. FLUSH=1 with IF_VALID=1 and EX_VALID=1 -> EX_VALID=0 next cycle, nothing captured. FLUSH & RST together -> reset values.
6. Opcode 0x7F -> EX_VALID=1, ILLEGAL=1, IMM_OUT=0. RST asserted mid-stall -> EX_VALID=0 and all outputs 0 the next cycle.
